box_animator: RTL and testbench
===============================

BOX_ANIMATOR -- requirements
Module: box_animator

Interface
REQ-001 Parameter BOX_SIZE, default 64, edge length of the square box in pixels.
REQ-002 Parameter H_DISPLAY, default 800; V_DISPLAY, default 600; visible area in pixels.
REQ-003 Clock  input  1  pixel clock; all state on rising edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 blank_n, sync_n, hSync_n, vSync_n  input  1 each  timing strobes from the VGA controller.
REQ-006 nextX  input  11, nextY  input  10  pixel coordinate from the VGA controller.
REQ-007 Speed  input  4  pixels moved per frame on each axis; 0 = stationary.
REQ-008 Pause  input  1  high freezes position, direction and colour.
REQ-009 red, green, blue  output  8 each  pixel colour.
REQ-010 blank_n_out, sync_n_out, hSync_n_out, vSync_n_out  output  1 each  input strobes delayed to align with colour.

Function
REQ-011 All outputs SHALL have exactly 2 cycles latency from the corresponding nextX/nextY/strobe inputs.
- stage 1: register coords and strobes.
- stage 2: compute and register colour; pass strobes through.
REQ-012 Frame tick SHALL be a one-cycle pulse on a vSync_n falling edge (previous-sample register high, current sample low).
REQ-013 Box state SHALL be posX (11 b), posY (10 b), per-axis direction {DIR_INC, DIR_DEC} and colour index (3 b).
- State updates only on a frame tick with Pause low.
REQ-014 Axis update: limits are LIM_X = H_DISPLAY-BOX_SIZE (736) and LIM_Y = V_DISPLAY-BOX_SIZE (536).
- DIR_INC: if pos+Speed >= LIM, pos := LIM and direction := DIR_DEC; else pos := pos+Speed.
- DIR_DEC: if pos <= Speed, pos := 0 and direction := DIR_INC; else pos := pos-Speed.
REQ-015 Arithmetic SHALL use one extra bit of width so that pos+Speed never wraps.
REQ-016 A tick on which either axis bounces SHALL increment the colour index by exactly 1, wrapping 7->0; simultaneous X and Y bounce is still +1.
REQ-017 Speed SHALL be sampled only on the tick cycle; changes mid-frame have no effect until the next tick.
REQ-018 Speed = 0 SHALL leave position, direction and colour unchanged, including when pos is 0 or at LIM.
REQ-019 Colour selection, registered in stage 2:
- delayed blank_n low -> 0x000000;
- inside box (posX <= x < posX+BOX_SIZE and posY <= y < posY+BOX_SIZE) -> PALETTE[colour index];
- otherwise -> background 0x000040 (red, green, blue = 00,00,40).
REQ-020 The comparison in REQ-019 SHALL use the box position held at stage-2 time; position changes only during vertical sync, so no tearing results.
REQ-021 Pause high on a tick SHALL suppress the update entirely; the missed tick SHALL NOT be replayed later.

Reset
REQ-022 On Reset_n low, all state SHALL reset asynchronously:
- posX = 368, posY = 268, both directions DIR_INC, colour index 0;
- vSync previous-sample register = 0, so no spurious tick at reset release.
REQ-023 During reset the outputs SHALL be: rgb = 0, blank_n_out = 0, sync_n_out = 1, hSync_n_out = 1, vSync_n_out = 1.
REQ-024 Reset asserted mid-frame or mid-pipeline SHALL discard all in-flight stage data; the first valid output is 2 cycles after release.

Structure
REQ-025 Package vga_pkg SHALL hold:
- timing constants (800/56/120/64, 600/37/6/23);
- BOX_SIZE default;
- dir_t enum;
- 8-entry 24-bit PALETTE: red, green, blue, yellow, cyan, magenta, white, orange;
- BACKGROUND constant.
REQ-026 Sub-module box_axis (parameter LIM, width W; ports: tick, Speed, position, direction, bounce) SHALL be instantiated once per axis.

Verification
REQ-027 Reset release, drive nextX = 400, nextY = 300, blank_n = 1 -> 2 cycles later rgb = PALETTE[0] = FF0000.
REQ-028 posX = 730, DIR_INC, Speed = 8, one tick -> posX = 736, X direction DIR_DEC, colour index 1.
REQ-029 posX = 3, posY = 533, both at their walls' direction, Speed = 5, one tick -> posX = 0, posY = 536, both directions flipped, colour index +1 only.
REQ-030 Toggle hSync_n/vSync_n/blank_n pattern on the inputs -> identical pattern on the _out ports delayed exactly 2 cycles; blank_n low -> rgb = 000000.
REQ-031 Pause = 1 across 3 ticks, then Pause = 0 for 1 tick, Speed = 4 -> position advances by 4 only.
REQ-032 Assert Reset_n low mid-line with box pixels in flight -> outputs go immediately to reset values; posX/posY return to 368/268.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the bouncing-box pattern generator.
//   - 800x600 VGA timing constants (display / front porch / sync / back porch)
//   - default box edge length
//   - dir_t: per-axis direction of travel
//   - PALETTE: 8 x 24-bit RGB box colours, index 0 = red
//   - BACKGROUND: colour of visible pixels outside the box
package vga_pkg;

  localparam int H_DISPLAY_C = 800;
  localparam int H_FRONT     = 56;
  localparam int H_SYNC      = 120;
  localparam int H_BACK      = 64;

  localparam int V_DISPLAY_C = 600;
  localparam int V_FRONT     = 37;
  localparam int V_SYNC      = 6;
  localparam int V_BACK      = 23;

  localparam int BOX_SIZE_DEFAULT = 64;

  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } dir_t;

  // Packed so that PALETTE[0] is the right-most entry (red).
  localparam logic [7:0][23:0] PALETTE = {
    24'hFFA500,  // 7 orange
    24'hFFFFFF,  // 6 white
    24'hFF00FF,  // 5 magenta
    24'h00FFFF,  // 4 cyan
    24'hFFFF00,  // 3 yellow
    24'h0000FF,  // 2 blue
    24'h00FF00,  // 1 green
    24'hFF0000   // 0 red
  };

  localparam logic [23:0] BACKGROUND = 24'h000040;

endpackage

// File: rtl/box_axis.sv
// box_axis: position/direction state of the box along one axis.
//   Clock, Reset_n : pixel clock, async active-low reset
//   tick           : frame update strobe (already gated by pause)
//   Speed          : pixels per tick; 0 leaves the axis untouched
//   position       : current box coordinate (registered)
//   direction      : current dir_t, as a plain bit (registered)
//   bounce         : high during a tick that clamps against a wall
module box_axis
  import vga_pkg::*;
#(
  parameter int W    = 11,
  parameter int LIM  = 736,
  parameter int INIT = 368
) (
  input  logic         Clock,
  input  logic         Reset_n,
  input  logic         tick,
  input  logic [3:0]   Speed,
  output logic [W-1:0] position,
  output logic         direction,
  output logic         bounce
);

  localparam logic [W:0]   LIM_EXT  = LIM[W:0];
  localparam logic [W-1:0] LIM_POS  = LIM[W-1:0];
  localparam logic [W-1:0] INIT_POS = INIT[W-1:0];

  dir_t         dir_r;
  dir_t         dir_nxt_s;
  logic [W-1:0] pos_r;
  logic [W-1:0] pos_nxt_s;
  logic [W:0]   pos_ext_s;
  logic [W:0]   spd_ext_s;
  logic [W:0]   sum_s;
  logic         bounce_s;

  // One guard bit so pos+Speed can exceed the limit without wrapping.
  assign pos_ext_s = {1'b0, pos_r};
  assign spd_ext_s = {{(W-3){1'b0}}, Speed};
  assign sum_s     = pos_ext_s + spd_ext_s;

  // Next position/direction; Speed 0 must not flip direction at a wall.
  always_comb begin
    pos_nxt_s = pos_r;
    dir_nxt_s = dir_r;
    bounce_s  = 1'b0;
    if (tick && (Speed != 4'd0)) begin
      case (dir_r)
        DIR_INC: begin
          if (sum_s >= LIM_EXT) begin
            pos_nxt_s = LIM_POS;
            dir_nxt_s = DIR_DEC;
            bounce_s  = 1'b1;
          end else begin
            pos_nxt_s = sum_s[W-1:0];
          end
        end
        DIR_DEC: begin
          if (pos_ext_s <= spd_ext_s) begin
            pos_nxt_s = {W{1'b0}};
            dir_nxt_s = DIR_INC;
            bounce_s  = 1'b1;
          end else begin
            pos_nxt_s = pos_r - spd_ext_s[W-1:0];
          end
        end
        default: begin
          pos_nxt_s = pos_r;
          dir_nxt_s = DIR_INC;
        end
      endcase
    end else begin
      pos_nxt_s = pos_r;
    end
  end

  // Axis state register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      pos_r <= INIT_POS;
      dir_r <= DIR_INC;
    end else begin
      pos_r <= pos_nxt_s;
      dir_r <= dir_nxt_s;
    end
  end

  assign position  = pos_r;
  assign direction = dir_r;
  // Same-cycle strobe: consumed by the colour register on the tick edge.
  assign bounce    = bounce_s;

endmodule

// File: rtl/box_animator.sv
// box_animator: draws a square box that bounces around the visible area,
// changing colour on every wall hit. Two-stage pipeline, 2 cycles latency.
//   Clock, Reset_n                      : pixel clock, async active-low reset
//   blank_n, sync_n, hSync_n, vSync_n   : timing strobes from the VGA controller
//   nextX[10:0], nextY[9:0]             : coordinate of the pixel being requested
//   Speed[3:0]                          : pixels moved per frame per axis
//   Pause                               : freeze position, direction and colour
//   red, green, blue[7:0]               : pixel colour (registered)
//   *_out                               : input strobes delayed to match colour
module box_animator
  import vga_pkg::*;
#(
  parameter int BOX_SIZE  = BOX_SIZE_DEFAULT,
  parameter int H_DISPLAY = 800,
  parameter int V_DISPLAY = 600
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        blank_n,
  input  logic        sync_n,
  input  logic        hSync_n,
  input  logic        vSync_n,
  input  logic [10:0] nextX,
  input  logic [9:0]  nextY,
  input  logic [3:0]  Speed,
  input  logic        Pause,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        blank_n_out,
  output logic        sync_n_out,
  output logic        hSync_n_out,
  output logic        vSync_n_out
);

  localparam int LIM_X  = H_DISPLAY - BOX_SIZE;
  localparam int LIM_Y  = V_DISPLAY - BOX_SIZE;
  localparam int INIT_X = LIM_X / 2;
  localparam int INIT_Y = LIM_Y / 2;

  localparam logic [11:0] BOX_W = BOX_SIZE[11:0];
  localparam logic [10:0] BOX_H = BOX_SIZE[10:0];

  // stage 1
  logic [10:0] x1_r;
  logic [9:0]  y1_r;
  logic        blank1_r;
  logic        sync1_r;
  logic        hs1_r;
  logic        vs1_r;

  // frame tick and box state
  logic        vs_prev_r;
  logic        tick_s;
  logic [10:0] pos_x_s;
  logic [9:0]  pos_y_s;
  logic        dir_x_s;
  logic        dir_y_s;
  logic        bounce_x_s;
  logic        bounce_y_s;
  logic [2:0]  colour_idx_r;

  // stage 2 colour
  logic [11:0] x_ext_s;
  logic [11:0] x_lo_s;
  logic [11:0] x_hi_s;
  logic [10:0] y_ext_s;
  logic [10:0] y_lo_s;
  logic [10:0] y_hi_s;
  logic        inside_s;
  logic [23:0] rgb_nxt_s;

  // Falling edge of the raw vSync_n input; pause swallows the tick outright.
  assign tick_s = vs_prev_r & ~vSync_n & ~Pause;

  // Previous vSync_n sample; resets low so releasing reset cannot fake an edge.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_prev_r <= 1'b0;
    end else begin
      vs_prev_r <= vSync_n;
    end
  end

  box_axis #(
    .W    (11),
    .LIM  (LIM_X),
    .INIT (INIT_X)
  ) u_axis_x (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .tick      (tick_s),
    .Speed     (Speed),
    .position  (pos_x_s),
    .direction (dir_x_s),
    .bounce    (bounce_x_s)
  );

  box_axis #(
    .W    (10),
    .LIM  (LIM_Y),
    .INIT (INIT_Y)
  ) u_axis_y (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .tick      (tick_s),
    .Speed     (Speed),
    .position  (pos_y_s),
    .direction (dir_y_s),
    .bounce    (bounce_y_s)
  );

  // Colour index: one step per bouncing tick, even if both axes bounce.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      colour_idx_r <= 3'd0;
    end else if (tick_s && (bounce_x_s || bounce_y_s)) begin
      colour_idx_r <= colour_idx_r + 3'd1;
    end else begin
      colour_idx_r <= colour_idx_r;
    end
  end

  // Stage 1: capture coordinate and strobes.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      x1_r     <= 11'd0;
      y1_r     <= 10'd0;
      blank1_r <= 1'b0;
      sync1_r  <= 1'b1;
      hs1_r    <= 1'b1;
      vs1_r    <= 1'b1;
    end else begin
      x1_r     <= nextX;
      y1_r     <= nextY;
      blank1_r <= blank_n;
      sync1_r  <= sync_n;
      hs1_r    <= hSync_n;
      vs1_r    <= vSync_n;
    end
  end

  // Widened bounds so posX+BOX_SIZE cannot wrap near the right/bottom edge.
  assign x_ext_s  = {1'b0, x1_r};
  assign x_lo_s   = {1'b0, pos_x_s};
  assign x_hi_s   = x_lo_s + BOX_W;
  assign y_ext_s  = {1'b0, y1_r};
  assign y_lo_s   = {1'b0, pos_y_s};
  assign y_hi_s   = y_lo_s + BOX_H;
  assign inside_s = (x_ext_s >= x_lo_s) && (x_ext_s < x_hi_s) &&
                    (y_ext_s >= y_lo_s) && (y_ext_s < y_hi_s);

  // Stage 2 colour select: blanking wins, then box, then background.
  always_comb begin
    rgb_nxt_s = 24'h000000;
    if (!blank1_r) begin
      rgb_nxt_s = 24'h000000;
    end else if (inside_s) begin
      rgb_nxt_s = PALETTE[colour_idx_r];
    end else begin
      rgb_nxt_s = BACKGROUND;
    end
  end

  // Stage 2: register colour and forward the strobes.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      red         <= 8'h00;
      green       <= 8'h00;
      blue        <= 8'h00;
      blank_n_out <= 1'b0;
      sync_n_out  <= 1'b1;
      hSync_n_out <= 1'b1;
      vSync_n_out <= 1'b1;
    end else begin
      red         <= rgb_nxt_s[23:16];
      green       <= rgb_nxt_s[15:8];
      blue        <= rgb_nxt_s[7:0];
      blank_n_out <= blank1_r;
      sync_n_out  <= sync1_r;
      hSync_n_out <= hs1_r;
      vSync_n_out <= vs1_r;
    end
  end

endmodule

// File: tb/tb_box_animator.sv
// Scoreboard bench for box_animator: every driven pixel pushes its expected
// colour/strobes; a negedge monitor pops and compares when the result is due.
module tb_box_animator;
  import vga_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        blank_n, sync_n, hSync_n, vSync_n;
  logic [10:0] nextX;
  logic [9:0]  nextY;
  logic [3:0]  Speed;
  logic        Pause;
  logic [7:0]  red, green, blue;
  logic        blank_n_out, sync_n_out, hSync_n_out, vSync_n_out;

  box_animator dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .blank_n(blank_n), .sync_n(sync_n), .hSync_n(hSync_n), .vSync_n(vSync_n),
    .nextX(nextX), .nextY(nextY), .Speed(Speed), .Pause(Pause),
    .red(red), .green(green), .blue(blue),
    .blank_n_out(blank_n_out), .sync_n_out(sync_n_out),
    .hSync_n_out(hSync_n_out), .vSync_n_out(vSync_n_out)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [23:0] rgb;
    logic [3:0]  strb;   // {blank, sync, hsync, vsync}
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // bench-side model of the box
  int         mx, my;
  logic       mdx, mdy;
  logic [2:0] mcol;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] exp_pixel(int x, int y, logic bl);
    if (!bl) return 24'h000000;
    if (x >= mx && x < mx + 64 && y >= my && y < my + 64) return PALETTE[mcol];
    return BACKGROUND;
  endfunction

  // Monitor: compare outputs whenever a scoreboard entry falls due.
  always @(negedge Clock) begin
    if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
      mon_e = sb_q.pop_front();
      check("rgb", {8'h00, red, green, blue}, {8'h00, mon_e.rgb});
      check("strobes", {28'h0, blank_n_out, sync_n_out, hSync_n_out, vSync_n_out},
            {28'h0, mon_e.strb});
    end
  end

  task automatic apply(int x, int y, logic bl, logic sy, logic hs, logic vs,
                       logic [3:0] spd, logic [23:0] rgb);
    exp_t e;
    nextX = 11'(x); nextY = 10'(y);
    blank_n = bl; sync_n = sy; hSync_n = hs; vSync_n = vs; Speed = spd;
    e.due = cyc + 2; e.rgb = rgb; e.strb = {bl, sy, hs, vs};
    sb_q.push_back(e);
  endtask

  task automatic drive(int x, int y, logic bl, logic sy, logic hs, logic vs,
                       logic [3:0] spd, logic [23:0] rgb);
    @(negedge Clock);
    apply(x, y, bl, sy, hs, vs, spd, rgb);
  endtask

  task automatic model_axis(inout int p, inout logic d, input int lim,
                            input int s, output logic b);
    b = 1'b0;
    if (s != 0) begin
      if (d == 1'b0) begin
        if (p + s >= lim) begin p = lim; d = 1'b1; b = 1'b1; end
        else p = p + s;
      end else begin
        if (p <= s) begin p = 0; d = 1'b0; b = 1'b1; end
        else p = p - s;
      end
    end
  endtask

  task automatic check_model();
    check("posX_model", 32'(dut.pos_x_s), 32'(mx));
    check("posY_model", 32'(dut.pos_y_s), 32'(my));
    check("dirX_model", 32'(dut.dir_x_s), 32'(mdx));
    check("dirY_model", 32'(dut.dir_y_s), 32'(mdy));
    check("colour_model", 32'(dut.colour_idx_r), 32'(mcol));
  endtask

  // One vertical-sync pulse; Speed is only correct on the tick cycle.
  task automatic do_tick(int spd, logic pz);
    logic [3:0] junk;
    logic       bx, by;
    junk  = 4'(spd) ^ 4'hA;
    Pause = pz;
    drive(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, junk, 24'h0);
    drive(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 4'(spd), 24'h0);
    drive(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, junk, 24'h0);
    drive(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, junk, 24'h0);
    if (!pz) begin
      model_axis(mx, mdx, 736, spd, bx);
      model_axis(my, mdy, 536, spd, by);
      if (bx || by) mcol = mcol + 3'd1;
    end
    check_model();
  endtask

  task automatic seg(int n, int spd);
    for (int i = 0; i < n; i++) do_tick(spd, 1'b0);
  endtask

  // Hand-computed state checkpoint.
  task automatic cp(string nm, int x, int y, int dx, int dy, int col);
    check({nm, "_posX"}, 32'(dut.pos_x_s), 32'(x));
    check({nm, "_posY"}, 32'(dut.pos_y_s), 32'(y));
    check({nm, "_dirX"}, 32'(dut.dir_x_s), 32'(dx));
    check({nm, "_dirY"}, 32'(dut.dir_y_s), 32'(dy));
    check({nm, "_colour"}, 32'(dut.colour_idx_r), 32'(col));
  endtask

  // Pixels on and just outside every box edge.
  task automatic probe();
    drive(mx, my, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7, exp_pixel(mx, my, 1'b1));
    drive(mx + 63, my + 63, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7, exp_pixel(mx + 63, my + 63, 1'b1));
    drive(mx + 64, my, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7, exp_pixel(mx + 64, my, 1'b1));
    drive(mx, my + 64, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7, exp_pixel(mx, my + 64, 1'b1));
    if (mx > 0) drive(mx - 1, my, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7, exp_pixel(mx - 1, my, 1'b1));
    if (my > 0) drive(mx, my - 1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7, exp_pixel(mx, my - 1, 1'b1));
  endtask

  logic [11:0] hs_pat, vs_pat, bl_pat, sy_pat;

  initial begin
    Reset_n = 1'b0; Pause = 1'b0; Speed = 4'd0;
    blank_n = 1'b0; sync_n = 1'b1; hSync_n = 1'b1; vSync_n = 1'b1;
    nextX = 11'd0; nextY = 10'd0;
    mx = 368; my = 268; mdx = 1'b0; mdy = 1'b0; mcol = 3'd0;

    // reset values
    repeat (3) @(negedge Clock);
    check("rst_rgb", {8'h00, red, green, blue}, 32'h0);
    check("rst_strobes", {28'h0, blank_n_out, sync_n_out, hSync_n_out, vSync_n_out}, 32'h7);
    cp("rst", 368, 268, 0, 0, 0);
    Reset_n = 1'b1;

    // centre pixel is red, pixel outside is background
    drive(400, 300, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 24'hFF0000);
    drive(100, 100, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 24'h000040);
    drive(400, 300, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 24'h000000);
    probe();

    // strobe pattern while paused: delayed copy, blank_n low gives black
    hs_pat = 12'b101100111010; vs_pat = 12'b110011101101;
    bl_pat = 12'b011101101110; sy_pat = 12'b100110110011;
    Pause = 1'b1;
    for (int i = 0; i < 12; i++)
      drive(mx + 60 + i, my + 10, bl_pat[i], sy_pat[i], hs_pat[i], vs_pat[i], 4'd3,
            exp_pixel(mx + 60 + i, my + 10, bl_pat[i]));
    drive(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 24'h0);
    cp("strobe_pause", 368, 268, 0, 0, 0);
    Pause = 1'b0;

    // bounce sequence (Y top, X right, Y bottom, X left, Y top, X+Y together)
    seg(17, 15); seg(1, 13);
    cp("bounce1", 636, 536, 0, 1, 1); probe();
    seg(6, 15); seg(1, 9);
    cp("pre_wall", 735, 437, 0, 1, 1);
    seg(1, 15);
    cp("bounce2", 736, 422, 1, 1, 2); probe();
    seg(28, 15); seg(1, 2);
    cp("bounce3", 314, 0, 1, 0, 3); probe();
    seg(20, 15); seg(1, 13); seg(1, 15);
    cp("bounce4", 0, 328, 0, 0, 4); probe();
    seg(13, 15); seg(1, 13);
    cp("bounce5", 208, 536, 0, 1, 5);
    seg(35, 15);
    cp("pre_double", 733, 11, 0, 1, 5);
    seg(1, 11);
    cp("double", 736, 0, 1, 0, 6); probe();
    seg(1, 0);
    cp("speed0", 736, 0, 1, 0, 6);

    // paused ticks are lost, one live tick moves by 4
    for (int i = 0; i < 3; i++) do_tick(4, 1'b1);
    do_tick(4, 1'b0);
    cp("pause", 732, 4, 1, 0, 6); probe();

    // reset mid-line with box pixels in flight
    drive(mx + 1, my + 1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, exp_pixel(mx + 1, my + 1, 1'b1));
    drive(mx + 2, my + 1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, exp_pixel(mx + 2, my + 1, 1'b1));
    #2 Reset_n = 1'b0;
    #1;
    sb_q.delete();
    check("midrst_rgb", {8'h00, red, green, blue}, 32'h0);
    check("midrst_strobes", {28'h0, blank_n_out, sync_n_out, hSync_n_out, vSync_n_out}, 32'h7);
    cp("midrst", 368, 268, 0, 0, 0);
    mx = 368; my = 268; mdx = 1'b0; mdy = 1'b0; mcol = 3'd0;
    repeat (2) @(negedge Clock);
    check("midrst_hold_rgb", {8'h00, red, green, blue}, 32'h0);

    // release with vSync_n already low: no tick, first output after 2 cycles
    @(negedge Clock);
    Reset_n = 1'b1;
    apply(400, 300, 1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 24'hFF0000);
    @(negedge Clock);
    check("rel_latency_rgb", {8'h00, red, green, blue}, 32'h0);
    check("rel_latency_blank", {31'h0, blank_n_out}, 32'h0);
    drive(401, 301, 1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 24'hFF0000);
    drive(300, 300, 1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 24'h000040);
    cp("no_spurious", 368, 268, 0, 0, 0);
    do_tick(4, 1'b0);
    cp("after_rst", 372, 272, 0, 0, 0); probe();

    repeat (4) @(negedge Clock);
    check("scoreboard_drain", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
